// File: rtl/gpu_video_pkg.sv
// Shared video definitions for the GPU display path: panel timing,
// pixel type and the scanout fetch FSM state encoding.
package gpu_video_pkg;

    // 1024x600 panel timing, in pixel clocks and lines
    localparam int H_DISP  = 1024;
    localparam int H_SYNC  = 136;
    localparam int H_BACK  = 160;
    localparam int H_TOTAL = 1344;
    localparam int V_DISP  = 600;
    localparam int V_SYNC  = 6;
    localparam int V_BACK  = 29;
    localparam int V_TOTAL = 638;
    // the encoder raises Request this many cycles before the draw area
    localparam int H_AHEAD = 1;

    // {R[23:16], G[15:8], B[7:0]}
    typedef logic [23:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/gpu_sync_fifo.sv
// Single-clock FIFO with exact occupancy count and registered read data.
// The read register only updates on a pop, so it holds the last popped word.
module gpu_sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic [WIDTH-1:0] pop_data_reg;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == (AW+1)'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign count    = count_reg;
    assign pop_data = pop_data_reg;

    // storage array, no reset so it can map onto block RAM
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // pointers, occupancy and the registered read port
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            pop_data_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                pop_data_reg <= mem_reg[rd_ptr_reg];
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/gpu_scanout_fetch.sv
// Scanout pixel source: fetches the framebuffer linearly in fixed bursts,
// buffers it in a FIFO and hands one pixel to the TMDS encoder per Request.
// Pixels served while the FIFO is empty are counted as debt and the same
// number of later beats are dropped so that pixels stay aligned to addresses.
module gpu_scanout_fetch #(
    parameter int          H_DISP        = gpu_video_pkg::H_DISP,
    parameter int          V_DISP        = gpu_video_pkg::V_DISP,
    parameter int          ADDR_W        = 20,
    parameter int          FB_BASE       = 0,
    parameter int          FIFO_DEPTH    = 32,
    parameter int          BURST_LEN     = 8,
    parameter logic [23:0] UNDERFLOW_RGB = 24'h000000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              Request,
    output logic [23:0]       RGB,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_ack,
    input  logic              rd_valid,
    input  logic [23:0]       rd_data,
    output logic              underflow,
    output logic              frame_done
);
    import gpu_video_pkg::*;

    localparam int FRAME_PIX = H_DISP * V_DISP;
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam int BEAT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int PIX_W     = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;

    localparam logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(FB_BASE);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FB_BASE + FRAME_PIX - BURST_LEN);
    localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    localparam logic [PIX_W-1:0]  LAST_PIX   = PIX_W'(FRAME_PIX - 1);
    localparam logic [15:0]       DEBT_MAX   = 16'hFFFF;

    fetch_state_t      state_reg;
    logic              rd_req_reg;
    logic [ADDR_W-1:0] rd_addr_reg;
    logic [BEAT_W-1:0] beat_cnt_reg;
    logic [15:0]       debt_reg;
    logic [15:0]       debt_next;
    logic [PIX_W-1:0]  pix_cnt_reg;
    logic              frame_done_reg;
    logic              underflow_reg;
    logic              under_sel_reg;

    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    pixel_t            fifo_rdata;

    logic              pop_en;
    logic              under_en;
    logic              beat_en;
    logic              drop_en;
    logic              push_en;
    logic              credit_ok;

    assign pop_en    = Request && !fifo_empty;
    assign under_en  = Request && fifo_empty;
    assign beat_en   = (state_reg == DATA) && rd_valid;
    assign drop_en   = beat_en && (debt_reg != 16'd0);
    assign push_en   = beat_en && (debt_reg == 16'd0) && !fifo_full;
    // a whole burst must fit before it is requested, so pushes never meet a full FIFO
    assign credit_ok = (int'(fifo_count) + BURST_LEN) <= FIFO_DEPTH;

    gpu_sync_fifo #(
        .WIDTH (24),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (push_en),
        .push_data (rd_data),
        .pop       (pop_en),
        .pop_data  (fifo_rdata),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // both terms are registers: the FIFO read register and the underflow select
    assign RGB        = under_sel_reg ? UNDERFLOW_RGB : fifo_rdata;
    assign rd_req     = rd_req_reg;
    assign rd_addr    = rd_addr_reg;
    assign underflow  = underflow_reg;
    assign frame_done = frame_done_reg;

    // burst fetch sequencer: credit check, request handshake, beat counting
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= IDLE;
            rd_req_reg   <= 1'b0;
            rd_addr_reg  <= BASE_ADDR;
            beat_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (credit_ok) begin
                        state_reg  <= REQ;
                        rd_req_reg <= 1'b1;
                    end
                end
                REQ: begin
                    if (rd_ack) begin
                        state_reg    <= DATA;
                        rd_req_reg   <= 1'b0;
                        beat_cnt_reg <= '0;
                    end
                end
                DATA: begin
                    if (rd_valid) begin
                        if (beat_cnt_reg == LAST_BEAT) begin
                            state_reg   <= IDLE;
                            rd_addr_reg <= (rd_addr_reg == LAST_ADDR) ? BASE_ADDR
                                                                      : rd_addr_reg + BURST_STEP;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg  <= IDLE;
                    rd_req_reg <= 1'b0;
                end
            endcase
        end
    end

    // debt: grows on each underflow pixel, shrinks on each dropped beat, saturating
    always_comb begin
        debt_next = debt_reg;
        if (under_en && !drop_en) begin
            if (debt_reg != DEBT_MAX) begin
                debt_next = debt_reg + 16'd1;
            end
        end else if (drop_en && !under_en) begin
            debt_next = debt_reg - 16'd1;
        end
    end

    // served-pixel bookkeeping: underflow select/flag, debt and frame position
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            under_sel_reg  <= 1'b0;
            underflow_reg  <= 1'b0;
            debt_reg       <= 16'd0;
            pix_cnt_reg    <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            debt_reg       <= debt_next;
            frame_done_reg <= 1'b0;
            if (Request) begin
                under_sel_reg <= fifo_empty;
                if (fifo_empty) begin
                    underflow_reg <= 1'b1;
                end
                if (pix_cnt_reg == LAST_PIX) begin
                    pix_cnt_reg    <= '0;
                    frame_done_reg <= 1'b1;
                end else begin
                    pix_cnt_reg <= pix_cnt_reg + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_gpu_scanout_fetch.sv
// Directed bench for gpu_scanout_fetch: a full-size instance for fetch,
// pop, handshake, underflow and reset behaviour, and a tiny-frame instance
// for address wrap and frame_done.
module tb_gpu_scanout_fetch;

    logic        clk = 1'b0;
    logic        rstn;
    logic        Request;
    logic [23:0] RGB;
    logic        rd_req;
    logic [19:0] rd_addr;
    logic        rd_ack;
    logic        rd_valid;
    logic [23:0] rd_data;
    logic        underflow;
    logic        frame_done;

    logic        s_rstn;
    logic        s_Request;
    logic [23:0] s_RGB;
    logic        s_rd_req;
    logic [19:0] s_rd_addr;
    logic        s_rd_ack;
    logic        s_rd_valid;
    logic [23:0] s_rd_data;
    logic        s_underflow;
    logic        s_frame_done;

    int tests = 0;
    int fails = 0;

    localparam logic [23:0] UF_RGB = 24'hABCDEF;

    always #5 clk = ~clk;

    gpu_scanout_fetch #(
        .UNDERFLOW_RGB (UF_RGB)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .Request    (Request),
        .RGB        (RGB),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ack     (rd_ack),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .underflow  (underflow),
        .frame_done (frame_done)
    );

    gpu_scanout_fetch #(
        .H_DISP     (4),
        .V_DISP     (2),
        .FIFO_DEPTH (8),
        .BURST_LEN  (4)
    ) dut_s (
        .clk        (clk),
        .rstn       (s_rstn),
        .Request    (s_Request),
        .RGB        (s_RGB),
        .rd_req     (s_rd_req),
        .rd_addr    (s_rd_addr),
        .rd_ack     (s_rd_ack),
        .rd_valid   (s_rd_valid),
        .rd_data    (s_rd_data),
        .underflow  (s_underflow),
        .frame_done (s_frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // wait for a request, optionally withhold the ack, then return nbeats
    // beats of data0+i starting three cycles after the ack
    task automatic serve_burst(input bit sm, input int exp_addr, input int hold,
                               input int data0, input int nbeats, input string tag);
        int          w;
        logic        cur_req;
        logic [19:0] cur_addr;
        logic [19:0] a0;
        bit          stable;
        w = 0;
        cur_req = sm ? s_rd_req : rd_req;
        while (!cur_req && w < 60) begin
            @(negedge clk);
            w++;
            cur_req = sm ? s_rd_req : rd_req;
        end
        cur_addr = sm ? s_rd_addr : rd_addr;
        chk({tag, "_req"}, 32'(cur_req), 32'd1);
        chk({tag, "_addr"}, 32'(cur_addr), 32'(exp_addr));
        a0 = cur_addr;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            cur_req  = sm ? s_rd_req : rd_req;
            cur_addr = sm ? s_rd_addr : rd_addr;
            if (!cur_req || cur_addr != a0) stable = 1'b0;
        end
        if (hold > 0) chk({tag, "_stable"}, 32'(stable), 32'd1);
        if (sm) s_rd_ack = 1'b1; else rd_ack = 1'b1;
        @(negedge clk);
        if (sm) s_rd_ack = 1'b0; else rd_ack = 1'b0;
        cur_req = sm ? s_rd_req : rd_req;
        chk({tag, "_drop"}, 32'(cur_req), 32'd0);
        repeat (2) @(negedge clk);
        for (int i = 0; i < nbeats; i++) begin
            if (sm) begin
                s_rd_valid = 1'b1;
                s_rd_data  = 24'(data0 + i);
            end else begin
                rd_valid = 1'b1;
                rd_data  = 24'(data0 + i);
            end
            @(negedge clk);
        end
        if (sm) s_rd_valid = 1'b0; else rd_valid = 1'b0;
        $display("[TB] burst %s addr=%0d beats=%0d", tag, exp_addr, nbeats);
    endtask

    // hold Request for n cycles on the full-size instance, checking each pixel
    task automatic pop_n(input int n, input int first, input string tag);
        Request = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk(tag, 32'(RGB), 32'(24'(first + i)));
        end
        Request = 1'b0;
        $display("[TB] pop %s n=%0d first=%0d", tag, n, first);
    endtask

    // hold Request for 8 cycles on the small instance: pixels and frame pulse
    task automatic pop_frame_s(input int first, input string tag);
        s_Request = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk({tag, "_rgb"}, 32'(s_RGB), 32'(first + i));
            chk({tag, "_fd"}, 32'(s_frame_done), (i == 7) ? 32'd1 : 32'd0);
        end
        s_Request = 1'b0;
        @(negedge clk);
        chk({tag, "_fd_end"}, 32'(s_frame_done), 32'd0);
        $display("[TB] frame %s first=%0d", tag, first);
    endtask

    initial begin
        bit idle_ok;
        rstn = 1'b0; Request = 1'b0; rd_ack = 1'b0; rd_valid = 1'b0; rd_data = '0;
        s_rstn = 1'b0; s_Request = 1'b0; s_rd_ack = 1'b0; s_rd_valid = 1'b0; s_rd_data = '0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_rgb", 32'(RGB), 32'd0);
        chk("rst_req", 32'(rd_req), 32'd0);
        chk("rst_addr", 32'(rd_addr), 32'd0);
        chk("rst_uf", 32'(underflow), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        $display("[TB] reset values checked");
        rstn = 1'b1;
        s_rstn = 1'b1;

        // fill: four bursts, then no more requests with a full FIFO
        serve_burst(0, 0, 0, 0, 8, "b0");
        serve_burst(0, 8, 0, 8, 8, "b8");
        serve_burst(0, 16, 0, 16, 8, "b16");
        serve_burst(0, 24, 0, 24, 8, "b24");
        idle_ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rd_req) idle_ok = 1'b0;
        end
        chk("full_no_req", 32'(idle_ok), 32'd1);
        chk("full_count", 32'(dut.fifo_count), 32'd32);

        // pop 0..3, no burst at count 28, RGB holds, then pop to 24 -> burst at 32
        pop_n(4, 0, "pop0");
        idle_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rd_req) idle_ok = 1'b0;
        end
        chk("c28_no_req", 32'(idle_ok), 32'd1);
        chk("rgb_hold", 32'(RGB), 32'd3);
        chk("c28_count", 32'(dut.fifo_count), 32'd28);
        pop_n(4, 4, "pop4");
        serve_burst(0, 32, 0, 32, 8, "b32");

        // ack withheld for 50 cycles
        pop_n(8, 8, "pop8");
        serve_burst(0, 40, 50, 40, 8, "b40_hold");

        // drain, then underflow three times
        pop_n(32, 16, "drain");
        Request = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("uf_rgb", 32'(RGB), 32'(UF_RGB));
        end
        Request = 1'b0;
        chk("uf_flag", 32'(underflow), 32'd1);
        chk("uf_debt", 32'(dut.debt_reg), 32'd3);
        serve_burst(0, 48, 0, 0, 8, "b48_debt");
        chk("debt_paid", 32'(dut.debt_reg), 32'd0);
        chk("debt_count", 32'(dut.fifo_count), 32'd5);
        pop_n(3, 3, "after_uf");
        chk("uf_sticky", 32'(underflow), 32'd1);

        // reset in the middle of a burst
        serve_burst(0, 56, 0, 56, 4, "b56_part");
        rd_valid = 1'b1; rd_data = 24'd60;
        rstn = 1'b0;
        #1;
        chk("mid_rst_rgb", 32'(RGB), 32'd0);
        chk("mid_rst_req", 32'(rd_req), 32'd0);
        chk("mid_rst_addr", 32'(rd_addr), 32'd0);
        chk("mid_rst_uf", 32'(underflow), 32'd0);
        chk("mid_rst_fd", 32'(frame_done), 32'd0);
        chk("mid_rst_count", 32'(dut.fifo_count), 32'd0);
        @(negedge clk);
        rstn = 1'b1; rd_data = 24'd61;
        @(negedge clk);
        rd_data = 24'd62;
        @(negedge clk);
        rd_data = 24'd63;
        @(negedge clk);
        rd_valid = 1'b0;
        chk("stale_beats_count", 32'(dut.fifo_count), 32'd0);
        serve_burst(0, 0, 0, 200, 8, "b0_restart");
        pop_n(1, 200, "restart_pop");

        // tiny frame: addresses 0,4,0,4 and frame_done every 8 pixels
        serve_burst(1, 0, 0, 0, 4, "s_b0");
        serve_burst(1, 4, 0, 4, 4, "s_b4");
        pop_frame_s(0, "s_f0");
        serve_burst(1, 0, 0, 8, 4, "s_b0_wrap");
        serve_burst(1, 4, 0, 12, 4, "s_b4_again");
        pop_frame_s(8, "s_f1");
        chk("s_no_uf", 32'(s_underflow), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
